// File: rtl/ghost_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ghost_move_scheduler
//  Description : Time-shares a single-port maze-wall ROM among four ghosts.
//                On each game tick every ghost's four neighbour tiles are
//                looked up in turn, and its can_move nibble is refreshed. A
//                one-hot step_en pulse then lets only that ghost advance.
//  Options     : TUNNEL_WRAP_EN - LEFT from x=0 and RIGHT from x=MAP_W-1
//                wrap horizontally and read the ROM. When it is undefined,
//                every map edge is a forced wall.
//  Revision    : 1.0 - initial release
// ============================================================================
module ghost_move_scheduler #(
  parameter int MAP_W  = 28,
  parameter int MAP_H  = 36,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [47:0]       ghost_pos,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_re,
  input  logic              rom_wall,
  output logic [15:0]       can_move,
  output logic [3:0]        step_en,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    QUERY = 3'd1,
    DRAIN = 3'd2,
    STEP  = 3'd3,
    FIN   = 3'd4
  } state_t;

  // Direction index k, also selects the nibble bit (bit 3-k, i.e. ~k)
  localparam logic [1:0] K_UP    = 2'd0;
  localparam logic [1:0] K_RIGHT = 2'd1;
  localparam logic [1:0] K_DOWN  = 2'd2;
  localparam logic [1:0] K_LEFT  = 2'd3;

  localparam logic signed [6:0] C_MAP_W = 7'(MAP_W);
  localparam logic signed [6:0] C_MAP_H = 7'(MAP_H);

  state_t      state_q, state_d;
  logic [1:0]  gidx_q, gidx_d;
  logic [1:0]  kidx_q, kidx_d;
  logic [47:0] pos_q, pos_d;
  logic [3:0]  shadow_q, shadow_d;
  logic        res_vld_q, res_vld_d;
  logic [1:0]  res_k_q, res_k_d;
  logic        res_forced_q, res_forced_d;
  logic [15:0] can_move_q, can_move_d;
  logic        overrun_q, overrun_d;

  logic [11:0]        w_gpos;
  logic signed [6:0]  w_nx;
  logic signed [6:0]  w_ny;
  logic               w_in_map;
  logic [ADDR_W-1:0]  w_addr;
  logic [3:0]         w_nibble;

  // Neighbour of the current ghost in the current direction.
  // Coordinates are widened to signed 7 bits so that off-map cases show up
  // as negative values or values >= the map size.
  always_comb begin
    w_gpos = pos_q[11:0];
    case (gidx_q)
      2'd0:    w_gpos = pos_q[11:0];
      2'd1:    w_gpos = pos_q[23:12];
      2'd2:    w_gpos = pos_q[35:24];
      default: w_gpos = pos_q[47:36];
    endcase
    w_nx = $signed({1'b0, w_gpos[11:6]});
    w_ny = $signed({1'b0, w_gpos[5:0]});
    case (kidx_q)
      K_UP:    w_ny = w_ny - 7'sd1;
      K_RIGHT: w_nx = w_nx + 7'sd1;
      K_DOWN:  w_ny = w_ny + 7'sd1;
      default: w_nx = w_nx - 7'sd1;
    endcase
`ifdef TUNNEL_WRAP_EN
    if (w_nx == -7'sd1) begin
      w_nx = C_MAP_W - 7'sd1;
    end else if (w_nx == C_MAP_W) begin
      w_nx = 7'sd0;
    end
`endif
    w_in_map = (w_nx >= 7'sd0) && (w_nx < C_MAP_W) &&
               (w_ny >= 7'sd0) && (w_ny < C_MAP_H);
    w_addr   = '0;
    if (w_in_map) begin
      w_addr = ADDR_W'(w_ny[5:0]) * ADDR_W'(MAP_W) + ADDR_W'(w_nx[5:0]);
    end
  end

  // Merge the result of the previous query (the ROM answers one cycle late).
  always_comb begin
    w_nibble = shadow_q;
    if (res_vld_q) begin
      w_nibble[~res_k_q] = res_forced_q ? 1'b0 : ~rom_wall;
    end
  end

  // Next-state and datapath updates for the sequencer
  always_comb begin
    state_d      = state_q;
    gidx_d       = gidx_q;
    kidx_d       = kidx_q;
    pos_d        = pos_q;
    shadow_d     = w_nibble;
    res_vld_d    = 1'b0;
    res_k_d      = res_k_q;
    res_forced_d = res_forced_q;
    can_move_d   = can_move_q;
    overrun_d    = tick && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (tick) begin
          pos_d   = ghost_pos;
          gidx_d  = 2'd0;
          kidx_d  = K_UP;
          state_d = QUERY;
        end
      end
      QUERY: begin
        res_vld_d    = 1'b1;
        res_k_d      = kidx_q;
        res_forced_d = ~w_in_map;
        if (kidx_q == K_LEFT) begin
          state_d = DRAIN;
        end else begin
          kidx_d = kidx_q + 2'd1;
        end
      end
      DRAIN: begin
        can_move_d[{gidx_q, 2'b00} +: 4] = w_nibble;
        state_d = STEP;
      end
      STEP: begin
        if (gidx_q == 2'd3) begin
          state_d = FIN;
        end else begin
          gidx_d  = gidx_q + 2'd1;
          kidx_d  = K_UP;
          state_d = QUERY;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; a reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gidx_q       <= 2'd0;
      kidx_q       <= 2'd0;
      pos_q        <= '0;
      shadow_q     <= '0;
      res_vld_q    <= 1'b0;
      res_k_q      <= 2'd0;
      res_forced_q <= 1'b0;
      can_move_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gidx_q       <= gidx_d;
      kidx_q       <= kidx_d;
      pos_q        <= pos_d;
      shadow_q     <= shadow_d;
      res_vld_q    <= res_vld_d;
      res_k_q      <= res_k_d;
      res_forced_q <= res_forced_d;
      can_move_q   <= can_move_d;
      overrun_q    <= overrun_d;
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    rom_re   = (state_q == QUERY) && w_in_map;
    rom_addr = (state_q == QUERY) ? w_addr : '0;
    busy     = (state_q == QUERY) || (state_q == DRAIN) || (state_q == STEP);
    done     = (state_q == FIN);
    step_en  = 4'b0000;
    if (state_q == STEP) begin
      step_en[gidx_q] = 1'b1;
    end
    can_move = can_move_q;
    overrun  = overrun_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ghost_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ghost_move_scheduler
//  Description : Randomised self-checking bench for ghost_move_scheduler with
//                a behavioural ROM and a tile-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ghost_move_scheduler;

  localparam int MAP_W  = 28;
  localparam int MAP_H  = 36;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              tick;
  logic [47:0]       ghost_pos;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_re;
  logic              rom_wall;
  logic [15:0]       can_move;
  logic [3:0]        step_en;
  logic              busy;
  logic              done;
  logic              overrun;

  bit          wall_mem [0:1023];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_cm;

  ghost_move_scheduler #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .ghost_pos(ghost_pos),
    .rom_addr (rom_addr),
    .rom_re   (rom_re),
    .rom_wall (rom_wall),
    .can_move (can_move),
    .step_en  (step_en),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Synchronous ROM; returns garbage when not enabled
  always @(posedge clk) begin
    rom_wall <= rom_re ? wall_mem[rom_addr] : 1'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Neighbour tile of (x,y) in direction k (0=up,1=right,2=down,3=left)
  function automatic void nbr(input int x, input int y, input int k,
                              output bit in_map, output int addr);
    int nx = x;
    int ny = y;
    case (k)
      0: ny = y - 1;
      1: nx = x + 1;
      2: ny = y + 1;
      default: nx = x - 1;
    endcase
`ifdef TUNNEL_WRAP_EN
    if (nx < 0) nx = MAP_W - 1;
    else if (nx >= MAP_W) nx = 0;
`endif
    in_map = (nx >= 0) && (nx < MAP_W) && (ny >= 0) && (ny < MAP_H);
    addr   = in_map ? ny * MAP_W + nx : 0;
  endfunction

  task automatic set_ghost(input int g, input int x, input int y);
    ghost_pos[12*g +: 12] = {6'(x), 6'(y)};
  endtask

  task automatic clear_walls();
    for (int i = 0; i < 1024; i++) wall_mem[i] = 1'b0;
  endtask

  // One tick-driven sequence, checked cycle by cycle for 26 cycles
  task automatic run_seq(input string name, input int tick2_c, input int pos_c, input int rst_c);
    logic [47:0] snap;
    bit          im [4][4];
    int          ad [4][4];
    logic [3:0]  nib [4];
    bit          aborted = 1'b0;
    tick = 1'b1;
    snap = ghost_pos;
    for (int g = 0; g < 4; g++) begin
      int x, y;
      x = int'(snap[12*g+6 +: 6]);
      y = int'(snap[12*g +: 6]);
      for (int k = 0; k < 4; k++) begin
        nbr(x, y, k, im[g][k], ad[g][k]);
        nib[g][3-k] = im[g][k] ? !wall_mem[ad[g][k]] : 1'b0;
      end
    end
    @(posedge clk); #1;
    tick = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      if (aborted) begin
        check($sformatf("%s c%0d busy", name, c), 32'(busy), 32'd0);
        check($sformatf("%s c%0d done", name, c), 32'(done), 32'd0);
        check($sformatf("%s c%0d step_en", name, c), 32'(step_en), 32'd0);
        check($sformatf("%s c%0d rom_re", name, c), 32'(rom_re), 32'd0);
        check($sformatf("%s c%0d can_move", name, c), 32'(can_move), 32'd0);
      end else begin
        logic [3:0] es;
        for (int g = 0; g < 4; g++) if (c == 6 + 6*g) exp_cm[4*g +: 4] = nib[g];
        es = (c % 6 == 0 && c <= 24) ? 4'(1 << (c/6 - 1)) : 4'd0;
        check($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(c <= 24));
        check($sformatf("%s c%0d done", name, c), 32'(done), 32'(c == 25));
        check($sformatf("%s c%0d step_en", name, c), 32'(step_en), 32'(es));
        check($sformatf("%s c%0d overrun", name, c), 32'(overrun),
              32'(tick2_c > 0 && c == tick2_c + 1));
        check($sformatf("%s c%0d can_move", name, c), 32'(can_move), 32'(exp_cm));
        if (c <= 24 && (c - 1) % 6 < 4) begin
          int g, k;
          g = (c - 1) / 6;
          k = (c - 1) % 6;
          check($sformatf("%s c%0d rom_re", name, c), 32'(rom_re), 32'(im[g][k]));
          if (im[g][k]) check($sformatf("%s c%0d rom_addr", name, c), 32'(rom_addr), 32'(ad[g][k]));
        end else begin
          check($sformatf("%s c%0d rom_re", name, c), 32'(rom_re), 32'd0);
        end
      end
      tick  = (c == tick2_c);
      reset = (c == rst_c);
      if (c == pos_c) ghost_pos = 48'({$urandom(), $urandom()});
      @(posedge clk); #1;
      if (reset) begin
        aborted = 1'b1;
        exp_cm  = '0;
      end
      reset = 1'b0;
      tick  = 1'b0;
    end
  endtask

  function automatic int rand_coord(input int maxv);
    case ($urandom % 4)
      0:       return 0;
      1:       return maxv - 1;
      default: return int'($urandom_range(0, maxv - 1));
    endcase
  endfunction

  initial begin
    reset     = 1'b1;
    tick      = 1'b0;
    ghost_pos = '0;
    exp_cm    = '0;
    clear_walls();
    repeat (3) @(posedge clk);
    #1;
    check("rst rom_addr", 32'(rom_addr), 32'd0);
    check("rst rom_re", 32'(rom_re), 32'd0);
    check("rst can_move", 32'(can_move), 32'd0);
    check("rst step_en", 32'(step_en), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    set_ghost(0, 13, 17);
    set_ghost(1, 1, 1);
    set_ghost(2, 26, 33);
    set_ghost(3, 5, 20);
    run_seq("open", 0, 0, 0);
    check("open all", 32'(can_move), 32'hFFFF);

    wall_mem[461] = 1'b1;
    wall_mem[488] = 1'b1;
    run_seq("walls", 0, 0, 0);
    check("walls g0", 32'(can_move[3:0]), 32'h6);

    clear_walls();
    set_ghost(0, 0, 0);
    run_seq("corner", 0, 0, 0);
`ifdef TUNNEL_WRAP_EN
    check("corner g0", 32'(can_move[3:0]), 32'h7);
`else
    check("corner g0", 32'(can_move[3:0]), 32'h6);
`endif

    set_ghost(0, 13, 17);
    run_seq("ovr", 10, 3, 0);
    run_seq("rst", 0, 0, 8);
    run_seq("after_rst", 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      int t2;
      for (int a = 0; a < 1024; a++) wall_mem[a] = ($urandom % 4 == 0);
      for (int g = 0; g < 4; g++) set_ghost(g, rand_coord(MAP_W), rand_coord(MAP_H));
      t2 = ($urandom % 3 == 0) ? int'($urandom_range(1, 25)) : 0;
      run_seq($sformatf("rnd%0d", i), t2, int'($urandom_range(1, 24)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ghost_move_scheduler.md
Name: ghost_move_scheduler

Overview:
Sequences a shared single-port maze-wall ROM among the four ghost controllers once per game tick. For each ghost it looks up the four neighbouring tiles in turn and latches that ghost's canMoveUp/Right/Down/Left flags. It then pulses a per-ghost step enable so only one ghost's movement logic advances on fresh flags. It sits between the frame/tick generator, the maze ROM and the ghost movement blocks.

Parameters:
MAP_W, 28, maze width in tiles (x range 0..MAP_W-1)
MAP_H, 36, maze height in tiles (y range 0..MAP_H-1)
ADDR_W, 10, ROM address width; address = y*MAP_W + x

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
tick  in  1  one-cycle game-tick strobe; starts a sequence
ghost_pos  in  48  4 x {x[5:0],y[5:0]}; ghost g at bits [12g+11:12g], x in upper 6 bits
rom_addr  out  ADDR_W  maze ROM read address
rom_re  out  1  ROM read enable
rom_wall  in  1  ROM data, 1 = wall; valid the cycle after rom_re
can_move  out  16  4 x {up,right,down,left}; ghost g at bits [4g+3:4g], bit 3 = up
step_en  out  4  one-hot, one-cycle pulse: ghost g may move
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at sequence end
overrun  out  1  one-cycle pulse when a tick arrives while busy

Behaviour:
- Reset values: rom_addr=0, rom_re=0, can_move=0, step_en=0, busy=0, done=0, overrun=0; FSM=IDLE. Reset mid-sequence aborts it immediately; no step_en is issued.
- FSM states: IDLE, QUERY, DRAIN, STEP, FIN.
- IDLE:
  - tick=1 at edge T: snapshot all ghost_pos into internal registers, set g=0, k=0, go to QUERY.
  - busy=1 from T+1.
  - ghost_pos changes after the snapshot have no effect on the current sequence.
- QUERY (4 cycles per ghost, k=0..3 = UP, RIGHT, DOWN, LEFT):
  - Neighbour offsets: UP=(x,y-1), RIGHT=(x+1,y), DOWN=(x,y+1), LEFT=(x-1,y).
  - In-map neighbour: rom_re=1, rom_addr = ny*MAP_W + nx.
  - Off-map neighbour (y=0 up, y=MAP_H-1 down, x=0 left, x=MAP_W-1 right): rom_re=0, result forced to wall. The cycle is still consumed.
  - Results come from rom_wall one cycle later and are collected into a shadow nibble; can_move bit = !wall.
  - After k=3, go to DRAIN.
- DRAIN (1 cycle):
  - Capture the k=3 result.
  - Write the full shadow nibble into can_move[g] at the end of this cycle. The other ghosts' nibbles are unchanged.
- STEP (1 cycle):
  - step_en[g]=1; can_move[g] already holds the new value this cycle.
  - If g<3: g=g+1, k=0, go to QUERY. Otherwise go to FIN.
- FIN (1 cycle): done=1, busy=0, go to IDLE.
- Timing from tick at T:
  - ghost g queries at T+1+6g .. T+4+6g
  - step_en[g] at T+6+6g, i.e. T+6, T+12, T+18, T+24
  - done at T+25
  - busy high T+1..T+24
  - Total 25 cycles; ticks must be spaced at least 26 cycles apart.
- tick while FSM is not IDLE: ignored, overrun pulses for 1 cycle, sequence continues. tick in the same cycle as FIN is also ignored and flagged as overrun.
- can_move holds its last values between sequences.
- Arithmetic:
  - Neighbour coords computed in 7-bit signed to detect off-map before the address is formed.
  - The address multiply-add uses ADDR_W bits; max address MAP_W*MAP_H-1 = 1007 fits.

Optional Feature:
TUNNEL_WRAP_EN:
- Defined: horizontal tunnel wrap.
  - LEFT from x=0 looks up (MAP_W-1, y) with rom_re=1.
  - RIGHT from x=MAP_W-1 looks up (0, y) with rom_re=1.
  - Vertical edges are still forced walls.
- Undefined: all four map edges are forced walls with no ROM access.

Test Plan:
- All-open ROM (rom_wall=0), ghosts at (13,17), (1,1), (26,33), (5,20); tick -> can_move=16'hFFFF; step_en = 0001/0010/0100/1000 at T+6/12/18/24; done at T+25.
- Walls above and left of ghost0 at (13,17) (addresses 16*28+13=461 and 17*28+12=488 return 1) -> can_move[3:0]=4'b0110; rom_addr sequence 461, 490, 517, 488 at T+1..T+4.
- Ghost0 at (0,0), ROM all-open, macro undefined -> UP and LEFT cycles show rom_re=0; can_move[3:0]=4'b0110.
- Same as above with TUNNEL_WRAP_EN -> LEFT queries addr 27; can_move[3:0]=4'b0111.
- Second tick at T+10 -> overrun pulse at T+11; step_en/done timing unchanged; ghost_pos changed at T+3 does not alter ghost1–3 addresses.
- reset asserted at T+8 -> next cycle busy=0, can_move=0, no further step_en or done; a new tick afterwards runs a normal 25-cycle sequence.
